// File: rtl/inst_sram_responder.sv
// inst_sram_responder
//   Memory-side responder for an en/we/addr/wdata/rdata SRAM-like interface.
//   It behaves like a synchronous single-port RAM:
//     - fixed one-cycle read latency
//     - byte-lane writes with read-first data return
//     - windowed address decode that captures the first out-of-window address
//     - optional zero-fill of every word after reset
//     - read and write request counters
//
// Ports
//   clk           clock, all state changes on posedge
//   resetn        synchronous active-low reset
//   i_sram_en     request strobe
//   i_sram_we     byte write enables (4'b0000 = read)
//   i_sram_addr   byte address
//   i_sram_wdata  write data
//   o_sram_rdata  registered read data
//   o_init_done   high when requests are served
//   o_addr_err    sticky out-of-window flag
//   o_err_addr    address of the first out-of-window request
//   o_rd_count    accepted in-window reads
//   o_wr_count    accepted in-window writes
module inst_sram_responder #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h1C000000,
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_sram_en,
    input  logic [3:0]  i_sram_we,
    input  logic [31:0] i_sram_addr,
    input  logic [31:0] i_sram_wdata,
    output logic [31:0] o_sram_rdata,
    output logic        o_init_done,
    output logic        o_addr_err,
    output logic [31:0] o_err_addr,
    output logic [31:0] o_rd_count,
    output logic [31:0] o_wr_count
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {StInit, StReady} state_e;

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? StInit : StReady;

    state_e                r_state;
    state_e                w_state_d;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_rdata;
    logic                  r_addr_err;
    logic [31:0]           r_err_addr;
    logic [31:0]           r_rd_count;
    logic [31:0]           r_wr_count;

    logic                  w_init_wr;
    logic                  w_serve;
    logic [29:0]           w_off;
    logic                  w_in_win;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_oow;
    logic                  w_unused_addr_lsb;

    // Word access only: the byte offset within a word carries no meaning.
    assign w_unused_addr_lsb = ^i_sram_addr[1:0];

    // Addresses below the base wrap to huge offsets and so fall out of window.
    assign w_off    = i_sram_addr[31:2] - BASE_ADDR[31:2];
    assign w_in_win = {1'b0, w_off} < (31'd1 << ADDR_WIDTH);
    assign w_idx    = w_off[ADDR_WIDTH-1:0];

    assign w_rd  = w_serve && w_in_win && (i_sram_we == 4'b0000);
    assign w_wr  = w_serve && w_in_win && (i_sram_we != 4'b0000);
    assign w_oow = w_serve && !w_in_win;

    always_comb begin
        w_state_d = r_state;
        w_init_wr = 1'b0;
        w_serve   = 1'b0;
        unique case (r_state)
            StInit: begin
                w_init_wr = 1'b1;
                if (&r_init_cnt) begin
                    w_state_d = StReady;
                end
            end
            StReady: begin
                w_serve = i_sram_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= RESET_STATE;
            r_init_cnt <= '0;
            r_rdata    <= '0;
            r_addr_err <= 1'b0;
            r_err_addr <= '0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_init_wr) begin
                r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
            end
            // Non-blocking read of the array gives the pre-write word on writes.
            if (w_rd || w_wr) begin
                r_rdata <= r_mem[w_idx];
            end else if (w_oow) begin
                r_rdata <= '0;
            end
            if (w_rd) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_wr) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
            if (w_oow) begin
                r_addr_err <= 1'b1;
                if (!r_addr_err) begin
                    r_err_addr <= i_sram_addr;
                end
            end
        end
    end

    // Array has no reset; it is only cleared by the INIT sequencer.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (w_init_wr) begin
                r_mem[r_init_cnt] <= '0;
            end else if (w_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (i_sram_we[i]) begin
                        r_mem[w_idx][8*i +: 8] <= i_sram_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign o_sram_rdata = r_rdata;
    assign o_init_done  = (r_state == StReady);
    assign o_addr_err   = r_addr_err;
    assign o_err_addr   = r_err_addr;
    assign o_rd_count   = r_rd_count;
    assign o_wr_count   = r_wr_count;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Testbench for inst_sram_responder: a default-parameter instance checked
// against a behavioural memory model, and a small CLEAR_ON_RESET instance.
module tb_inst_sram_responder;
    localparam logic [31:0] BASE = 32'h1C000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        init_done;
    logic        addr_err;
    logic [31:0] err_addr;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    // CLEAR_ON_RESET instance
    logic        d1_resetn;
    logic        d1_en;
    logic [3:0]  d1_we;
    logic [31:0] d1_addr;
    logic [31:0] d1_wdata;
    logic [31:0] d1_rdata;
    logic        d1_init_done;
    logic        d1_addr_err;
    logic [31:0] d1_err_addr;
    logic [31:0] d1_rd_count;
    logic [31:0] d1_wr_count;

    inst_sram_responder dut0 (
        .clk          (clk),
        .resetn       (resetn),
        .i_sram_en    (en),
        .i_sram_we    (we),
        .i_sram_addr  (addr),
        .i_sram_wdata (wdata),
        .o_sram_rdata (rdata),
        .o_init_done  (init_done),
        .o_addr_err   (addr_err),
        .o_err_addr   (err_addr),
        .o_rd_count   (rd_count),
        .o_wr_count   (wr_count)
    );

    inst_sram_responder #(
        .ADDR_WIDTH     (4),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b1)
    ) dut1 (
        .clk          (clk),
        .resetn       (d1_resetn),
        .i_sram_en    (d1_en),
        .i_sram_we    (d1_we),
        .i_sram_addr  (d1_addr),
        .i_sram_wdata (d1_wdata),
        .o_sram_rdata (d1_rdata),
        .o_init_done  (d1_init_done),
        .o_addr_err   (d1_addr_err),
        .o_err_addr   (d1_err_addr),
        .o_rd_count   (d1_rd_count),
        .o_wr_count   (d1_wr_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model of the default instance (4096 words)
    logic [31:0] m_mem [4096];
    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] m_err_addr;
    logic [31:0] m_rd;
    logic [31:0] m_wr;

    task automatic m_step(input logic e, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d);
        logic [31:0] off;
        logic [31:0] mask;
        if (!e) return;
        off = ((a >> 2) - (BASE >> 2)) & 32'h3FFFFFFF;
        if (off < 32'd4096) begin
            m_rdata = m_mem[off];
            if (w == 4'b0000) begin
                m_rd = m_rd + 1;
            end else begin
                mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
                m_mem[off] = (m_mem[off] & ~mask) | (d & mask);
                m_wr = m_wr + 1;
            end
        end else begin
            m_rdata = 32'h0;
            if (!m_err) m_err_addr = a;
            m_err = 1'b1;
        end
    endtask

    // One request to the default instance, model updated in step.
    task automatic tick(input logic e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d);
        en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        m_step(e, w, a, d);
    endtask

    task automatic tick1(input logic e, input logic [3:0] w, input logic [31:0] a);
        d1_en = e; d1_we = w; d1_addr = a; d1_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        resetn = 1'b0;
        d1_resetn = 1'b0;
        en = 1'b0; we = '0; addr = '0; wdata = '0;
        d1_en = 1'b0; d1_we = '0; d1_addr = '0; d1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        m_rdata = '0; m_err = 1'b0; m_err_addr = '0; m_rd = '0; m_wr = '0;
        n_total++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata);
        else n_pass++;
        n_total++;
        if (addr_err !== 1'b0 || err_addr !== 32'h0)
            $display("FAIL reset_err: got %b/%h expected 0/0", addr_err, err_addr);
        else n_pass++;
        n_total++;
        if (rd_count !== 32'h0 || wr_count !== 32'h0)
            $display("FAIL reset_counts: got %0d/%0d expected 0/0", rd_count, wr_count);
        else n_pass++;
        n_total++;
        if (init_done !== 1'b1) $display("FAIL reset_init_done: got %b expected 1", init_done);
        else n_pass++;
        n_total++;
        if (d1_init_done !== 1'b0)
            $display("FAIL reset_init_done_clr: got %b expected 0", d1_init_done);
        else n_pass++;
        for (int i = 0; i < 4096; i++) begin
            v = $urandom;
            dut0.r_mem[i] = v;
            m_mem[i] = v;
        end
        resetn = 1'b1;
    endtask

    task automatic test_single_read;
        dut0.r_mem[0] = 32'h02800C06;
        m_mem[0] = 32'h02800C06;
        tick(1'b1, 4'b0000, 32'h1C000000, 32'h0);
        n_total++;
        if (rdata !== 32'h02800C06)
            $display("FAIL single_read_rdata: got %h expected 02800c06", rdata);
        else n_pass++;
        n_total++;
        if (rd_count !== 32'd1) $display("FAIL single_read_count: got %0d expected 1", rd_count);
        else n_pass++;
        n_total++;
        if (init_done !== 1'b1) $display("FAIL single_read_init: got %b expected 1", init_done);
        else n_pass++;
    endtask

    task automatic test_stream;
        logic [31:0] exp [3];
        for (int i = 0; i < 3; i++) begin
            exp[i] = $urandom;
            dut0.r_mem[i] = exp[i];
            m_mem[i] = exp[i];
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'b0000, BASE + 32'(4 * i), 32'h0);
            n_total++;
            if (rdata !== exp[i])
                $display("FAIL stream_rdata%0d: got %h expected %h", i, rdata, exp[i]);
            else n_pass++;
        end
        tick(1'b0, 4'b0000, BASE, 32'h0);
        n_total++;
        if (rdata !== exp[2]) $display("FAIL stream_hold: got %h expected %h", rdata, exp[2]);
        else n_pass++;
    endtask

    task automatic test_byte_write;
        tick(1'b1, 4'b1111, 32'h1C000010, 32'h11223344);
        tick(1'b1, 4'b0101, 32'h1C000010, 32'hAABBCCDD);
        n_total++;
        if (rdata !== 32'h11223344)
            $display("FAIL byte_write_read_first: got %h expected 11223344", rdata);
        else n_pass++;
        tick(1'b1, 4'b0000, 32'h1C000010, 32'h0);
        n_total++;
        if (rdata !== 32'h11BB33DD)
            $display("FAIL byte_write_merge: got %h expected 11bb33dd", rdata);
        else n_pass++;
        n_total++;
        if (wr_count !== 32'd2) $display("FAIL byte_write_count: got %0d expected 2", wr_count);
        else n_pass++;
        tick(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_out_of_window;
        logic [31:0] rd_before;
        tick(1'b1, 4'b0000, 32'h1BFFFFFC, 32'h0);
        n_total++;
        if (rdata !== 32'h0) $display("FAIL oow_rdata: got %h expected 0", rdata);
        else n_pass++;
        n_total++;
        if (addr_err !== 1'b1 || err_addr !== 32'h1BFFFFFC)
            $display("FAIL oow_err: got %b/%h expected 1/1bfffffc", addr_err, err_addr);
        else n_pass++;
        rd_before = m_rd;
        tick(1'b1, 4'b0000, 32'h1C004000, 32'h0);
        n_total++;
        if (err_addr !== 32'h1BFFFFFC)
            $display("FAIL oow_first_kept: got %h expected 1bfffffc", err_addr);
        else n_pass++;
        n_total++;
        if (rd_count !== rd_before)
            $display("FAIL oow_count: got %0d expected %0d", rd_count, rd_before);
        else n_pass++;
    endtask

    task automatic test_random;
        logic        e;
        logic [3:0]  w;
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 15) * 4);
            else a = $urandom;
            tick(e, w, a, $urandom);
            n_total++;
            if (rdata !== m_rdata)
                $display("FAIL random_rdata[%0d]: got %h expected %h", i, rdata, m_rdata);
            else n_pass++;
        end
        n_total++;
        if (rd_count !== m_rd || wr_count !== m_wr)
            $display("FAIL random_counts: got %0d/%0d expected %0d/%0d",
                     rd_count, wr_count, m_rd, m_wr);
        else n_pass++;
        n_total++;
        if (addr_err !== m_err || err_addr !== m_err_addr)
            $display("FAIL random_err: got %b/%h expected %b/%h",
                     addr_err, err_addr, m_err, m_err_addr);
        else n_pass++;
    endtask

    task automatic test_counter_wrap;
        dut0.r_rd_count = 32'hFFFFFFFF;
        m_rd = 32'hFFFFFFFF;
        tick(1'b1, 4'b0000, BASE + 32'h40, 32'h0);
        n_total++;
        if (rd_count !== 32'h0) $display("FAIL counter_wrap: got %h expected 0", rd_count);
        else n_pass++;
        n_total++;
        if (rdata !== m_rdata)
            $display("FAIL counter_wrap_rdata: got %h expected %h", rdata, m_rdata);
        else n_pass++;
    endtask

    task automatic test_clear_on_reset;
        int n;
        for (int i = 0; i < 16; i++) dut1.r_mem[i] = 32'hA5A50000 | 32'(i + 1);
        d1_resetn = 1'b1;
        // Requests during the fill must all be ignored.
        for (int k = 1; k <= 16; k++) begin
            case (k % 3)
                0:       tick1(1'b1, 4'b1111, BASE + 32'(4 * (k % 16)));
                1:       tick1(1'b1, 4'b0000, BASE + 32'(4 * (k % 16)));
                default: tick1(1'b1, 4'b0000, 32'h0);
            endcase
            n_total++;
            if (d1_rdata !== 32'h0 || d1_rd_count !== 32'h0 || d1_wr_count !== 32'h0 ||
                d1_addr_err !== 1'b0)
                $display("FAIL clr_ignored[%0d]: got %h/%0d/%0d/%b expected 0/0/0/0", k,
                         d1_rdata, d1_rd_count, d1_wr_count, d1_addr_err);
            else n_pass++;
            n_total++;
            if (d1_init_done !== (k == 16))
                $display("FAIL clr_init_done[%0d]: got %b expected %b", k, d1_init_done,
                         k == 16);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            tick1(1'b1, 4'b0000, BASE + 32'(4 * i));
            n_total++;
            if (d1_rdata !== 32'h0) $display("FAIL clr_word%0d: got %h expected 0", i, d1_rdata);
            else n_pass++;
        end
        n_total++;
        if (d1_rd_count !== 32'd16)
            $display("FAIL clr_rd_count: got %0d expected 16", d1_rd_count);
        else n_pass++;

        // Restart the fill mid-way and refill the array behind its back.
        d1_resetn = 1'b0;
        tick1(1'b0, 4'b0000, 32'h0);
        d1_resetn = 1'b1;
        repeat (5) tick1(1'b0, 4'b0000, 32'h0);
        n_total++;
        if (d1_init_done !== 1'b0)
            $display("FAIL clr_mid_init: got %b expected 0", d1_init_done);
        else n_pass++;
        d1_resetn = 1'b0;
        tick1(1'b0, 4'b0000, 32'h0);
        for (int i = 0; i < 16; i++) dut1.r_mem[i] = 32'h5A5A0000 | 32'(i + 1);
        d1_resetn = 1'b1;
        n = 0;
        while (n < 40 && d1_init_done !== 1'b1) begin
            tick1(1'b0, 4'b0000, 32'h0);
            n++;
        end
        n_total++;
        if (n !== 16) $display("FAIL clr_restart_len: got %0d expected 16", n);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            tick1(1'b1, 4'b0000, BASE + 32'(4 * i));
            n_total++;
            if (d1_rdata !== 32'h0)
                $display("FAIL clr_restart_word%0d: got %h expected 0", i, d1_rdata);
            else n_pass++;
        end
        tick1(1'b0, 4'b0000, 32'h0);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_stream();
        test_byte_write();
        test_out_of_window();
        test_random();
        test_counter_wrap();
        test_clear_on_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
